// File: rtl/seq_det_pkg.sv
// Shared types and sizing helpers for the serial pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_MAXLEN = 8;
    localparam int DEF_CNTW   = 8;

    function automatic int LENW(input int maxlen);
        return $clog2(maxlen + 1);
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Serial history shift register, fill counter and pattern compare.
// The compare looks at the history including the bit shifted in this cycle.
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int MAXLEN = DEF_MAXLEN,
    parameter int LW     = LENW(DEF_MAXLEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic              bit_i,
    input  logic [MAXLEN-1:0] pattern_i,
    input  logic [LW-1:0]     len_i,
    input  logic              ovl_i,
    output logic              match_o
);

    logic [MAXLEN-1:0] hist_q, hist_d, hist_shift;
    logic [LW-1:0]     fill_q, fill_d, fill_inc;
    logic              equal;

    // Only the low len_i bits take part in the compare.
    always_comb begin
        hist_shift = {hist_q[MAXLEN-2:0], bit_i};
        fill_inc   = (fill_q == LW'(MAXLEN)) ? fill_q : fill_q + LW'(1);
        equal      = 1'b1;
        for (int i = 0; i < MAXLEN; i++) begin
            if ((i < int'(len_i)) && (hist_shift[i] != pattern_i[i])) begin
                equal = 1'b0;
            end
        end
        match_o = shift_i && (fill_inc >= len_i) && equal;
    end

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_i) begin
            hist_d = hist_shift;
            fill_d = (match_o && !ovl_i) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for the serial pattern detector: FSM, configuration
// registers and match counter around seq_match_core.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAXLEN = DEF_MAXLEN,
    parameter int CNTW   = DEF_CNTW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [MAXLEN-1:0]       cfg_pattern,
    input  logic [LENW(MAXLEN)-1:0] cfg_len,
    input  logic                    cfg_ovl,
    input  logic [CNTW-1:0]         cfg_target,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    inp,
    input  logic                    inp_vld,
    output logic                    det,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [CNTW-1:0]         match_cnt
);

    localparam int LW = LENW(MAXLEN);

    state_e state_q, state_d;

    logic [MAXLEN-1:0] cfg_pat_q, cfg_pat_d;
    logic [LW-1:0]     cfg_len_q, cfg_len_d;
    logic              cfg_ovl_q, cfg_ovl_d;
    logic [CNTW-1:0]   cfg_tgt_q, cfg_tgt_d;

    logic [MAXLEN-1:0] run_pat_q, run_pat_d;
    logic [LW-1:0]     run_len_q, run_len_d;
    logic              run_ovl_q, run_ovl_d;
    logic [CNTW-1:0]   run_tgt_q, run_tgt_d;

    logic              err_q, err_d;
    logic              det_q, det_d;
    logic [CNTW-1:0]   cnt_q, cnt_d, cnt_inc;

    logic cfg_legal, idle_or_done, start_req, arm, reject, shift, match;

    always_comb begin
        idle_or_done = (state_q != RUN);
        cfg_legal    = (cfg_len_q != '0) && (cfg_len_q <= LW'(MAXLEN)) &&
                       (cfg_tgt_q != '0);
        start_req    = idle_or_done && start && !abort;
        arm          = start_req && cfg_legal;
        reject       = start_req && !cfg_legal;
        shift        = (state_q == RUN) && inp_vld && !abort;
        cnt_inc      = cnt_q + CNTW'(1);
    end

    seq_match_core #(
        .MAXLEN (MAXLEN),
        .LW     (LW)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (arm),
        .shift_i   (shift),
        .bit_i     (inp),
        .pattern_i (run_pat_q),
        .len_i     (run_len_q),
        .ovl_i     (run_ovl_q),
        .match_o   (match)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (arm) state_d = RUN;
            end
            RUN: begin
                if (abort)                               state_d = IDLE;
                else if (match && (cnt_inc == run_tgt_q)) state_d = DONE;
            end
            DONE: begin
                if (abort)       state_d = IDLE;
                else if (arm)    state_d = RUN;
                else if (reject) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        det       = det_q;
        err       = err_q;
        match_cnt = cnt_q;
    end

    // A start snapshots the stored configuration before any same-cycle
    // write lands, so a simultaneous write only affects the following run.
    always_comb begin
        cfg_pat_d = cfg_pat_q;
        cfg_len_d = cfg_len_q;
        cfg_ovl_d = cfg_ovl_q;
        cfg_tgt_d = cfg_tgt_q;
        run_pat_d = run_pat_q;
        run_len_d = run_len_q;
        run_ovl_d = run_ovl_q;
        run_tgt_d = run_tgt_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        det_d     = 1'b0;

        if (cfg_we && idle_or_done) begin
            cfg_pat_d = cfg_pattern;
            cfg_len_d = cfg_len;
            cfg_ovl_d = cfg_ovl;
            cfg_tgt_d = cfg_target;
        end

        if (arm) begin
            run_pat_d = cfg_pat_q;
            run_len_d = cfg_len_q;
            run_ovl_d = cfg_ovl_q;
            run_tgt_d = cfg_tgt_q;
            err_d     = 1'b0;
            cnt_d     = '0;
        end else if (reject) begin
            err_d = 1'b1;
        end

        if (match) begin
            cnt_d = cnt_inc;
            det_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_pat_q <= '0;
            cfg_len_q <= '0;
            cfg_ovl_q <= 1'b0;
            cfg_tgt_q <= '0;
            run_pat_q <= '0;
            run_len_q <= '0;
            run_ovl_q <= 1'b0;
            run_tgt_q <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            det_q     <= 1'b0;
        end else begin
            cfg_pat_q <= cfg_pat_d;
            cfg_len_q <= cfg_len_d;
            cfg_ovl_q <= cfg_ovl_d;
            cfg_tgt_q <= cfg_tgt_d;
            run_pat_q <= run_pat_d;
            run_len_q <= run_len_d;
            run_ovl_q <= run_ovl_d;
            run_tgt_q <= run_tgt_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            det_q     <= det_d;
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed scenarios plus randomized traffic for seq_det_ctrl, checked
// against a queue-based model of received bits.
module tb_seq_det_ctrl;

    localparam int MAXLEN = 8;
    localparam int CNTW   = 8;
    localparam int LW     = $clog2(MAXLEN + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_we = 1'b0;
    logic [MAXLEN-1:0] cfg_pattern = '0;
    logic [LW-1:0]     cfg_len = '0;
    logic              cfg_ovl = 1'b0;
    logic [CNTW-1:0]   cfg_target = '0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              inp = 1'b0;
    logic              inp_vld = 1'b0;
    logic              det, busy, done, err;
    logic [CNTW-1:0]   match_cnt;

    int errors = 0;
    int checks = 0;

    // Model: 0 = idle, 1 = running, 2 = finished
    int mState, mCnt;
    bit mDet, mErr;
    int sPat, sLen, sOvl, sTgt;
    int aPat, aLen, aOvl, aTgt;
    int win[$];

    seq_det_ctrl #(
        .MAXLEN (MAXLEN),
        .CNTW   (CNTW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_ovl     (cfg_ovl),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .inp         (inp),
        .inp_vld     (inp_vld),
        .det         (det),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .match_cnt   (match_cnt)
    );

    always #5 clk = ~clk;

    function automatic void modelReset();
        mState = 0; mCnt = 0; mDet = 0; mErr = 0;
        sPat = 0; sLen = 0; sOvl = 0; sTgt = 0;
        aPat = 0; aLen = 0; aOvl = 0; aTgt = 0;
        win.delete();
    endfunction

    function automatic bit tailMatches();
        if (win.size() < aLen) return 1'b0;
        for (int i = 0; i < aLen; i++) begin
            if (win[win.size() - 1 - i] != ((aPat >> i) & 1)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void modelEdge();
        mDet = 1'b0;
        if (mState == 1) begin
            if (abort) begin
                mState = 0;
            end else if (inp_vld) begin
                win.push_back(int'(inp));
                if (tailMatches()) begin
                    mDet = 1'b1;
                    mCnt++;
                    if (aOvl == 0) win.delete();
                    if (mCnt == aTgt) mState = 2;
                end
            end
        end else begin
            if (abort) begin
                if (mState == 2) mState = 0;
            end else if (start) begin
                if (sLen == 0 || sLen > MAXLEN || sTgt == 0) begin
                    mErr = 1'b1;
                    mState = 0;
                end else begin
                    mErr = 1'b0;
                    mCnt = 0;
                    win.delete();
                    aPat = sPat; aLen = sLen; aOvl = sOvl; aTgt = sTgt;
                    mState = 1;
                end
            end
            if (cfg_we) begin
                sPat = int'(cfg_pattern);
                sLen = int'(cfg_len);
                sOvl = int'(cfg_ovl);
                sTgt = int'(cfg_target);
            end
        end
    endfunction

    task automatic checkOutput(input string tag);
        logic expBusy, expDone;
        logic [CNTW-1:0] expCnt;
        expBusy = (mState == 1);
        expDone = (mState == 2);
        expCnt  = CNTW'(mCnt);
        checks++;
        assert (det === mDet) else begin
            errors++;
            $error("[TB] FAIL %s det: got %b expected %b", tag, det, mDet);
        end
        checks++;
        assert (busy === expBusy) else begin
            errors++;
            $error("[TB] FAIL %s busy: got %b expected %b", tag, busy, expBusy);
        end
        checks++;
        assert (done === expDone) else begin
            errors++;
            $error("[TB] FAIL %s done: got %b expected %b", tag, done, expDone);
        end
        checks++;
        assert (err === mErr) else begin
            errors++;
            $error("[TB] FAIL %s err: got %b expected %b", tag, err, mErr);
        end
        checks++;
        assert (match_cnt === expCnt) else begin
            errors++;
            $error("[TB] FAIL %s match_cnt: got %0d expected %0d", tag, match_cnt, expCnt);
        end
    endtask

    task automatic applyStimulus(input bit we, input bit st, input bit ab,
                                 input bit vld, input bit b, input string tag);
        cfg_we  = we;
        start   = st;
        abort   = ab;
        inp_vld = vld;
        inp     = b;
        modelEdge();
        @(posedge clk);
        #1;
        cfg_we  = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        inp_vld = 1'b0;
        checkOutput(tag);
    endtask

    task automatic cfgWrite(input int pat, input int len, input bit ovl,
                            input int tgt, input string tag);
        cfg_pattern = MAXLEN'(pat);
        cfg_len     = LW'(len);
        cfg_ovl     = ovl;
        cfg_target  = CNTW'(tgt);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic feedBits(input int bits, input int n, input int gap, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'((bits >> i) & 1), tag);
            for (int g = 0; g < gap; g++) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {tag, " gap"});
            end
        end
    endtask

    initial begin
        int r;
        bit we;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        rst_n = 1'b1;

        $display("[TB] unconfigured start and legal arm");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "s4 start unconfigured");
        cfgWrite(3'b101, 3, 1'b0, 8, "s4 cfg");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "s4 legal start");

        $display("[TB] non-overlapping 101");
        feedBits(5'b10101, 5, 0, "s1 stream");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "s1 abort");

        $display("[TB] overlapping 101");
        cfgWrite(3'b101, 3, 1'b1, 8, "s2 cfg");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "s2 start");
        feedBits(5'b10101, 5, 0, "s2 stream");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "s2 start in run");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "s2 abort");

        $display("[TB] overlapping 11 to target");
        cfgWrite(2'b11, 2, 1'b1, 3, "s3 cfg");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "s3 start");
        feedBits(5'b11111, 5, 0, "s3 stream");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "s3 abort from done");

        $display("[TB] gapped bits and abort on completing bit");
        cfgWrite(3'b101, 3, 1'b0, 8, "s5 cfg");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "s5 start");
        feedBits(3'b101, 3, 3, "s5 gapped");
        feedBits(2'b10, 2, 0, "s5 prefix");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "s5 abort with match");

        $display("[TB] write and start together");
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_target  = '0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "wr+start arms old cfg");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "wr+start abort");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "start with new illegal cfg");

        $display("[TB] async reset mid-run");
        cfgWrite(3'b101, 3, 1'b0, 8, "s6 cfg");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "s6 start");
        feedBits(2'b10, 2, 0, "s6 prefix");
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("s6 async reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("s6 reset held");
        feedBits(3'b101, 3, 0, "s6 post-reset stream");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "s6 start unconfigured");

        $display("[TB] randomized traffic");
        for (int c = 0; c < 600; c++) begin
            we = ($urandom_range(0, 9) == 0);
            if (we) begin
                r = $urandom_range(0, 9);
                cfg_pattern = MAXLEN'($urandom);
                cfg_len     = (r == 0) ? LW'(0) : (r == 9) ? LW'(9) : LW'((r % 3) + 1);
                cfg_ovl     = 1'($urandom_range(0, 1));
                cfg_target  = CNTW'($urandom_range(0, 5));
            end
            applyStimulus(we, $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
                          $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter MAXLEN, default 8, SHALL set the maximum pattern length in bits (2..16).
REQ-002 Parameter CNTW, default 8, SHALL set the width of the match counter and the target.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 cfg_we  input  1  SHALL be the configuration write strobe.
REQ-006 cfg_pattern  input  MAXLEN  SHALL be the pattern; bit [len-1] is received first, bit [0] last.
REQ-007 cfg_len  input  $clog2(MAXLEN+1)  SHALL be the pattern length in bits.
REQ-008 cfg_ovl  input  1  SHALL select overlapping (1) or non-overlapping (0) detection.
REQ-009 cfg_target  input  CNTW  SHALL be the number of matches that ends a run.
REQ-010 start  input  1  SHALL be the arm request.
REQ-011 abort  input  1  SHALL be the cancel request.
REQ-012 inp  input  1  SHALL be the serial data bit.
REQ-013 inp_vld  input  1  SHALL qualify inp; the bit is consumed only when inp_vld=1.
REQ-014 det  output  1  SHALL be a registered one-cycle match pulse.
REQ-015 busy  output  1  SHALL be 1 while in state RUN.
REQ-016 done  output  1  SHALL be 1 while in state DONE.
REQ-017 err  output  1  SHALL be a sticky flag indicating an illegal configuration at start.
REQ-018 match_cnt  output  CNTW  SHALL report the number of matches in the current or last run.

Function
REQ-019 The FSM SHALL have states IDLE, RUN and DONE.
REQ-020 Configuration registers SHALL load on cfg_we only in IDLE or DONE; in RUN, cfg_we SHALL be ignored.
REQ-021 start in IDLE or DONE with cfg_len=0, cfg_len>MAXLEN or cfg_target=0 SHALL set err, go to or stay in IDLE, and leave match_cnt unchanged.
REQ-022 A legal start SHALL clear err, match_cnt, the history and the fill count, and enter RUN on the next cycle.
REQ-023 In RUN, each inp_vld cycle SHALL shift inp into the history (newest bit at [0]) and increment the fill count, which saturates at MAXLEN.
REQ-024 A match SHALL occur when fill >= len and history[len-1:0] == pattern[len-1:0], both evaluated including the bit shifted in that cycle.
REQ-025 Latency: a bit completing a match at edge N SHALL cause det=1 during cycle N+1 only, with match_cnt incremented in the same cycle.
REQ-026 With cfg_ovl=0, a match SHALL reset the fill count to 0; with cfg_ovl=1, the fill count SHALL be kept so that suffix bits are reused.
REQ-027 When match_cnt reaches cfg_target, the FSM SHALL enter DONE and ignore further inp; match_cnt SHALL never exceed cfg_target.
REQ-028 Cycles with inp_vld=0 SHALL leave the history, the fill count and det=0 unchanged.
REQ-029 abort in RUN or DONE SHALL return the FSM to IDLE next cycle and retain match_cnt.
REQ-030 abort SHALL take priority over start and over a match in the same cycle; that match is not counted and det stays 0.
REQ-031 start in RUN SHALL be ignored.
REQ-032 Simultaneous cfg_we and start in IDLE SHALL arm with the previously stored configuration; the new values take effect on the next start.

Reset
REQ-033 rst_n=0 SHALL immediately force the state to IDLE and set det, busy, done, err, match_cnt, history, fill, pattern, len, ovl and target to 0, including mid-run.
REQ-034 After release, start without a prior cfg_we SHALL set err, because len=0.

Structure
REQ-035 Package seq_det_pkg SHALL hold the state enum (IDLE/RUN/DONE), the default MAXLEN and CNTW, and the LENW width function.
REQ-036 Sub-module seq_match_core SHALL contain the history shift register, the fill counter and the match compare; seq_det_ctrl SHALL hold the FSM, the configuration registers and the counter.

Verification
REQ-037 Scenario 1: pattern 101, len 3, ovl 0, target 8; stream 1,0,1,0,1 -> one det, one cycle after the 3rd bit; match_cnt=1.
REQ-038 Scenario 2: same stream with ovl 1 -> det after the 3rd and 5th bits; match_cnt=2.
REQ-039 Scenario 3: pattern 11, len 2, ovl 1, target 3; stream 1,1,1,1,1 -> matches on bits 2, 3 and 4; done=1 and busy=0 after the third match; the 5th bit is ignored; match_cnt=3.
REQ-040 Scenario 4: start after reset without configuration -> err=1, state stays IDLE; then a legal configuration and start -> err=0 and busy=1.
REQ-041 Scenario 5: inp_vld gaps of 3 cycles between the bits of 101 -> det still occurs exactly once; abort coinciding with the completing bit -> det=0, match_cnt unchanged, IDLE.
REQ-042 Scenario 6: rst_n asserted asynchronously mid-RUN, between clock edges -> all outputs 0 before the next edge; the post-reset stream produces no det.
